// File: rtl/riscv_pkg.sv
// Shared types for the branch-prediction resolution path: prediction record,
// resolver state and default FIFO pointer width.
package riscv_pkg;

  localparam int XLEN              = 32;
  localparam int PRED_RES_PTR_SIZE = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } pred_rec_t;

  typedef enum logic {
    RES_RUN,
    RES_FLUSH
  } res_state_t;

endpackage

// File: rtl/pred_fifo.sv
// Generic in-order FIFO with a clear input; the record type is a parameter.
// Pointers carry one extra wrap bit so full and empty stay distinguishable.
module pred_fifo #(
  parameter int  DEPTH = 4,
  parameter type rec_t = logic
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  rec_t wdata,
  output rec_t rdata,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  rec_t        mem [DEPTH];
  logic [PW:0] wptr;
  logic [PW:0] rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign rdata = mem[rptr[PW-1:0]];

  // Clear wins over push and pop: anything written in that cycle is discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      rptr <= wptr;
    end else begin
      if (push) wptr <= wptr + (PW+1)'(1);
      if (pop)  rptr <= rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pred_resolve.sv
// Resolves queued branch predictions against BU outcomes, drives the predictor
// update bus and the mispredict redirect. Optional perf counters: PRED_RESOLVE_PERF_EN.
module pred_resolve
  import riscv_pkg::*;
#(
  parameter int DEPTH     = 1 << PRED_RES_PTR_SIZE,
  parameter int FLUSH_LAT = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_push_v_i,
  input  logic [XLEN-1:0] if_pc_i,
  input  logic            if_pred_taken_i,
  input  logic [XLEN-1:0] if_pred_target_i,
  output logic            if_push_rdy_o,
  input  logic            bu_res_v_i,
  input  logic            bu_branch_i,
  input  logic            bu_taken_i,
  input  logic [XLEN-1:0] bu_target_i,
  output logic            pred_en_o,
  output logic [XLEN-1:0] bu_pc_branch_o,
  output logic [XLEN-1:0] bu_pc_target_o,
  output logic            pred_success_o,
  output logic            pred_failed_o,
  output logic            flush_o,
  output logic [XLEN-1:0] flush_pc_o,
`ifdef PRED_RESOLVE_PERF_EN
  output logic [31:0]     perf_branches_o,
  output logic [31:0]     perf_mispred_o,
`endif
  output logic            err_underflow_o
);

  localparam int CW = (FLUSH_LAT < 2) ? 1 : $clog2(FLUSH_LAT + 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  res_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  pred_rec_t       head_p0, push_rec_p0;
  logic            full, empty;
  logic            run_p0, vld_p0, underflow_p0, act_taken_p0, mispredict_p0, mis_vld_p0;

  logic            upd_vld_p1, succ_p1, fail_p1, flush_vld_p1, err_p1;
  logic [XLEN-1:0] pc_branch_p1, pc_target_p1, flush_pc_p1;

  assign push_rec_p0   = '{pc: if_pc_i, taken: if_pred_taken_i, target: if_pred_target_i};
  assign run_p0        = (state_q == RES_RUN);
  assign vld_p0        = bu_res_v_i && run_p0 && !empty;
  assign underflow_p0  = bu_res_v_i && run_p0 && empty;
  assign act_taken_p0  = bu_branch_i && bu_taken_i;
  assign mispredict_p0 = (head_p0.taken != act_taken_p0) ||
                         (act_taken_p0 && head_p0.taken && (head_p0.target != bu_target_i));
  assign mis_vld_p0    = vld_p0 && mispredict_p0;
  assign if_push_rdy_o = !full || vld_p0;

  pred_fifo #(
    .DEPTH (DEPTH),
    .rec_t (pred_rec_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (mis_vld_p0),
    .push    (if_push_v_i && if_push_rdy_o),
    .pop     (vld_p0),
    .wdata   (push_rec_p0),
    .rdata   (head_p0),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RES_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // BU results arriving during FLUSH belong to the wrong path and are dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RES_RUN: begin
        if (mis_vld_p0) begin
          state_d = RES_FLUSH;
          cnt_d   = CW'(FLUSH_LAT);
        end
      end
      RES_FLUSH: begin
        if (cnt_q <= CW'(1)) begin
          state_d = RES_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = RES_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // p0 -> p1: registered predictor update and redirect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_vld_p1   <= 1'b0;
      succ_p1      <= 1'b0;
      fail_p1      <= 1'b0;
      flush_vld_p1 <= 1'b0;
      err_p1       <= 1'b0;
      pc_branch_p1 <= '0;
      pc_target_p1 <= '0;
      flush_pc_p1  <= '0;
    end else begin
      upd_vld_p1   <= vld_p0 && bu_branch_i;
      succ_p1      <= vld_p0 && bu_branch_i && !mispredict_p0;
      fail_p1      <= vld_p0 && bu_branch_i && mispredict_p0;
      flush_vld_p1 <= mis_vld_p0;
      if (underflow_p0) err_p1 <= 1'b1;
      if (vld_p0 && bu_branch_i) begin
        pc_branch_p1 <= head_p0.pc;
        pc_target_p1 <= bu_target_i;
      end
      if (mis_vld_p0) flush_pc_p1 <= act_taken_p0 ? bu_target_i : head_p0.pc + XLEN'(4);
    end
  end

  assign pred_en_o       = upd_vld_p1;
  assign pred_success_o  = succ_p1;
  assign pred_failed_o   = fail_p1;
  assign bu_pc_branch_o  = pc_branch_p1;
  assign bu_pc_target_o  = pc_target_p1;
  assign flush_o         = flush_vld_p1;
  assign flush_pc_o      = flush_pc_p1;
  assign err_underflow_o = err_p1;

`ifdef PRED_RESOLVE_PERF_EN
  logic [31:0] perf_br_p2, perf_mis_p2;

  // p1 -> p2: counters follow the registered strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_br_p2  <= '0;
      perf_mis_p2 <= '0;
    end else begin
      if (upd_vld_p1) perf_br_p2  <= sat_inc(perf_br_p2);
      if (fail_p1)    perf_mis_p2 <= sat_inc(perf_mis_p2);
    end
  end

  assign perf_branches_o = perf_br_p2;
  assign perf_mispred_o  = perf_mis_p2;
`endif

endmodule

// File: doc/pred_resolve.md
Name: pred_resolve

Overview:
- Resolution-side companion of the branch predictor: tracks every fetched instruction's prediction in an in-order FIFO.
- Compares each prediction against the branch unit (BU) outcome when the instruction resolves.
- Drives the predictor update bus (pred_en / bu_pc_branch / bu_pc_target / pred_success / pred_failed) and a pipeline redirect on misprediction.
- Sits between fetch, BU and pred.

Parameters:
- DEPTH, 4, outstanding-prediction FIFO entries (power of 2, >=2).
- FLUSH_LAT, 2, cycles BU results are ignored after a redirect (wrong-path drain).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- if_push_v_i  in  1  fetch pushes one prediction record
- if_pc_i  in  XLEN  fetched instruction PC
- if_pred_taken_i  in  1  predictor said taken
- if_pred_target_i  in  XLEN  predicted target
- if_push_rdy_o  out  1  FIFO can accept
- bu_res_v_i  in  1  oldest instruction resolved
- bu_branch_i  in  1  resolved instruction is control flow
- bu_taken_i  in  1  actual direction
- bu_target_i  in  XLEN  actual target
- pred_en_o  out  1  predictor update strobe
- bu_pc_branch_o  out  XLEN  branch PC to predictor
- bu_pc_target_o  out  XLEN  actual target to predictor
- pred_success_o  out  1  prediction correct
- pred_failed_o  out  1  prediction wrong
- flush_o  out  1  pipeline redirect pulse
- flush_pc_o  out  XLEN  redirect PC
- err_underflow_o  out  1  sticky: resolve with empty FIFO

Behaviour:
- Reset:
  - All outputs 0, except if_push_rdy_o=1.
  - FIFO empty, rptr=wptr=0, state RUN, flush counter 0.
- FIFO:
  - Push when if_push_v_i & if_push_rdy_o.
  - if_push_rdy_o = ~full | pop, combinational.
  - Push and pop in the same cycle are both allowed at full or empty. Push+pop on an empty FIFO pops the old state, i.e. this is an underflow; the pushed record is kept.
  - Pointers are DEPTH-wrapped, with an extra wrap bit for full/empty.
- Pop: bu_res_v_i in state RUN with FIFO non-empty pops the head record {pc, ptaken, ptarget}.
- Compare, for the popped record:
  - mispredict = (ptaken != bu_taken_i) | (bu_taken_i & ptaken & ptarget != bu_target_i).
  - For non-branch (bu_branch_i=0), actual taken is 0.
- Predictor outputs, registered with 1-cycle latency after the pop:
  - Update only when bu_branch_i=1: pred_en_o=1, bu_pc_branch_o=pc, bu_pc_target_o=bu_target_i.
  - pred_success_o = ~mispredict; pred_failed_o = mispredict. The two are mutually exclusive.
  - Non-branch: pred_en_o=0. If ptaken=1, only the redirect is raised.
  - All strobes are single-cycle; data outputs hold their last value otherwise.
- Redirect:
  - On mispredict, flush_o=1 for one cycle, in the same registered cycle as pred_en_o.
  - flush_pc_o = bu_taken_i ? bu_target_i : pc+4. Arithmetic is modulo 2^XLEN.
  - FIFO is cleared (rptr=wptr) at the edge that registers flush_o.
  - Any push in that cycle is dropped.
- FSM:
  - RUN -> FLUSH on mispredict. FLUSH loads counter=FLUSH_LAT.
  - In FLUSH, bu_res_v_i is ignored (no pop, no update) and the counter decrements.
  - FLUSH -> RUN when counter reaches 1.
  - Pushes are accepted in FLUSH; these are correct-path records.
- Underflow: bu_res_v_i in RUN with an empty FIFO causes no update and sets err_underflow_o until reset.
- Mid-operation reset: everything returns to reset values immediately (asynchronous). No pending strobe survives reset.

Optional Feature:
- Macro PRED_RESOLVE_PERF_EN.
- When defined:
  - Adds 32-bit saturating counters perf_branches_o, perf_mispred_o (output ports).
  - Counters increment on each registered pred_en_o and pred_failed_o respectively.
  - Counters reset to 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- riscv_pkg gains:
  - typedef pred_rec_t {pc, taken, target}
  - enum res_state_t {RES_RUN, RES_FLUSH}
  - localparam PRED_RES_PTR_SIZE
- One sub-module, pred_fifo:
  - Generic synchronous FIFO with clear, parameterised on DEPTH and record type.
  - Reusable by fetch.

Test Plan:
- Push {pc=0x100, taken=1, tgt=0x200}; resolve branch taken tgt=0x200 -> next cycle pred_en_o=1, pred_success_o=1, branch=0x100, target=0x200, flush_o=0.
- Push {0x104, taken=0}; resolve branch taken tgt=0x300 -> pred_failed_o=1, flush_o=1, flush_pc_o=0x300. Next 2 resolves ignored; FIFO empty.
- Push {0x108, taken=1, tgt=0x400}; resolve non-branch -> pred_en_o=0, flush_o=1, flush_pc_o=0x10C.
- Fill 4 pushes -> if_push_rdy_o=0. Simultaneous push+resolve -> push accepted; order preserved across pointer wrap (8 records, all success).
- Resolve with empty FIFO -> no strobes; err_underflow_o=1, stays 1 until reset_n low.
- Assert reset_n low mid-FLUSH with 3 records queued -> all outputs 0, if_push_rdy_o=1, state RUN after release.
